// File: rtl/wgt_fifo_read_ctrl_pkg.sv
// Shared constants, FSM encoding and input normalisation for the weight FIFO read sequencer.
package wgt_fifo_read_ctrl_pkg;

  localparam int NUM_FIFO   = 16;
  localparam int CNT_WIDTH  = 13;
  localparam int PASS_WIDTH = 8;
  localparam int SIZE_W     = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } rd_state_t;

  // 0 or anything beyond the array width selects the full array
  function automatic logic [SIZE_W-1:0] norm_size(input logic [SIZE_W-1:0] s);
    if (s == '0 || int'(s) > NUM_FIFO) return SIZE_W'(NUM_FIFO);
    return s;
  endfunction

endpackage

// File: rtl/wgt_fifo_read_ctrl_skew.sv
// Diagonal skew shifter: column 0 enable ripples one column per cycle, masked to the active columns.
module wgt_skew_shift
  import wgt_fifo_read_ctrl_pkg::*;
#(
  parameter int NUM_FIFO = wgt_fifo_read_ctrl_pkg::NUM_FIFO
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en0,
  input  logic [SIZE_W-1:0]   k,
  output logic [NUM_FIFO-1:0] rd_en,
  output logic                drain_idle
);

  logic [NUM_FIFO-1:0] mask;
  logic [NUM_FIFO-1:0] sr_d, sr_q;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_FIFO; i++) mask[i] = (i < int'(k));
  end

  // Masking on the way in keeps inactive columns permanently clear.
  always_comb begin
    sr_d = {sr_q[NUM_FIFO-2:0], en0} & mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign rd_en = sr_q;
  // True when the next cycle has no enable left, assuming column 0 is no longer fed.
  assign drain_idle = (({sr_q[NUM_FIFO-2:0], 1'b0}) & mask) == '0;

endmodule

// File: rtl/wgt_fifo_read_ctrl.sv
// Weight FIFO read sequencer: per-pass rd_clr, skewed rd_en diagonal, multi-pass replay, done pulse.
module wgt_fifo_read_ctrl
  import wgt_fifo_read_ctrl_pkg::*;
#(
  parameter int NUM_FIFO   = wgt_fifo_read_ctrl_pkg::NUM_FIFO,
  parameter int CNT_WIDTH  = wgt_fifo_read_ctrl_pkg::CNT_WIDTH,
  parameter int PASS_WIDTH = wgt_fifo_read_ctrl_pkg::PASS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  read_len,
  input  logic [4:0]            read_wgt_size,
  input  logic [PASS_WIDTH-1:0] num_pass,
  output logic [NUM_FIFO-1:0]   rd_en,
  output logic                  rd_clr,
  output logic                  busy,
  output logic                  done
);

  rd_state_t             state_d, state_q;
  logic [CNT_WIDTH-1:0]  len_d, len_q;
  logic [SIZE_W-1:0]     k_d, k_q;
  logic [PASS_WIDTH-1:0] npass_d, npass_q;
  logic [CNT_WIDTH-1:0]  len_cnt_d, len_cnt_q;
  logic [PASS_WIDTH-1:0] pass_cnt_d, pass_cnt_q;
  logic                  en0;
  logic                  drain_idle;
  logic                  last_pass;

  assign last_pass = (pass_cnt_q == npass_q - 1'b1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    k_d        = k_q;
    npass_d    = npass_q;
    len_cnt_d  = len_cnt_q;
    pass_cnt_d = pass_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = read_len;
          k_d        = norm_size(read_wgt_size);
          npass_d    = (num_pass == '0) ? PASS_WIDTH'(1) : num_pass;
          pass_cnt_d = '0;
          state_d    = (read_len == '0) ? DONE : CLR;
        end
      end
      CLR: begin
        len_cnt_d = len_q;
        state_d   = READ;
      end
      READ: begin
        len_cnt_d = len_cnt_q - 1'b1;
        if (len_cnt_q == CNT_WIDTH'(1)) begin
          // With a single active column there is nothing to drain.
          if (!drain_idle)    state_d = DRAIN;
          else if (last_pass) state_d = DONE;
          else begin
            state_d    = CLR;
            pass_cnt_d = pass_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_idle) begin
          if (last_pass) state_d = DONE;
          else begin
            state_d    = CLR;
            pass_cnt_d = pass_cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Feeding the shifter from next-state lets rd_en[0] line up with the READ cycles.
  assign en0 = (state_d == READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      k_q        <= '0;
      npass_q    <= '0;
      len_cnt_q  <= '0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      k_q        <= k_d;
      npass_q    <= npass_d;
      len_cnt_q  <= len_cnt_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  wgt_skew_shift #(.NUM_FIFO(NUM_FIFO)) u_skew (
    .clk        (clk),
    .rst_n      (rst_n),
    .en0        (en0),
    .k          (k_q),
    .rd_en      (rd_en),
    .drain_idle (drain_idle)
  );

  assign rd_clr = (state_q == CLR);
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_wgt_fifo_read_ctrl.sv
// Directed bench for wgt_fifo_read_ctrl: timing, multi-pass, normalisation, ignore rules, async reset.
module tb_wgt_fifo_read_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [12:0] read_len;
  logic [4:0]  read_wgt_size;
  logic [7:0]  num_pass;
  logic [15:0] rd_en;
  logic        rd_clr;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  wgt_fifo_read_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .read_len      (read_len),
    .read_wgt_size (read_wgt_size),
    .num_pass      (num_pass),
    .rd_en         (rd_en),
    .rd_clr        (rd_clr),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // rel = cycles after the edge that samples start; rd_clr expected at rel 1
  task automatic run(input string nm, input logic [4:0] sz, input int kexp,
                     input logic [12:0] len, input logic [7:0] np, input int pexp,
                     input bit poke);
    int          en_cnt[16];
    int          first[16];
    int          last[16];
    int          clr_rel[2];
    int          clr_cnt, done_rel, plen, exp_done;
    logic [15:0] prev, mask;
    bit          fin;
    mask     = 16'((32'd1 << kexp) - 1);
    clr_cnt  = 0;
    done_rel = -1;
    clr_rel[0] = -1;
    clr_rel[1] = -1;
    for (int i = 0; i < 16; i++) begin
      en_cnt[i] = 0; first[i] = -1; last[i] = -1;
    end
    @(negedge clk);
    read_len = len; read_wgt_size = sz; num_pass = np; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev  = '0;
    fin   = 1'b0;
    for (int rel = 1; rel <= 12000 && !fin; rel++) begin
      chk({nm, ".ovl"}, 32'((|rd_en) && rd_clr), 0);
      chk({nm, ".skew"}, 32'(rd_en), 32'({prev[14:0], rd_en[0]} & mask));
      chk({nm, ".busy"}, 32'(busy), 1);
      for (int i = 0; i < 16; i++) if (rd_en[i]) begin
        en_cnt[i]++;
        if (first[i] < 0) first[i] = rel;
        last[i] = rel;
      end
      if (rd_clr) begin
        if (clr_cnt < 2) clr_rel[clr_cnt] = rel;
        clr_cnt++;
      end
      if (done) begin
        done_rel = rel;
        fin = 1'b1;
      end
      prev = rd_en;
      if (poke && rel == 5) begin
        start = 1'b1; read_len = 13'd1; read_wgt_size = 5'd2; num_pass = 8'd1;
      end
      if (poke && rel == 6) start = 1'b0;
      @(negedge clk);
    end
    if (!fin) chk({nm, ".timeout"}, 0, 1);
    chk({nm, ".idle_busy"}, 32'(busy), 0);
    chk({nm, ".idle_done"}, 32'(done), 0);
    chk({nm, ".idle_en"}, 32'(rd_en), 0);
    plen     = int'(len) + kexp;
    exp_done = (len == 0) ? 1 : 1 + pexp * plen;
    chk({nm, ".done_rel"}, done_rel, exp_done);
    chk({nm, ".clr_cnt"}, clr_cnt, (len == 0) ? 0 : pexp);
    if (len != 0) chk({nm, ".clr0"}, clr_rel[0], 1);
    if (len != 0 && pexp >= 2) chk({nm, ".clr1"}, clr_rel[1], 1 + plen);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s.en_cnt[%0d]", nm, i), en_cnt[i], (i < kexp) ? int'(len) * pexp : 0);
      if (i < kexp && len != 0) begin
        chk($sformatf("%s.first[%0d]", nm, i), first[i], 2 + i);
        chk($sformatf("%s.last[%0d]", nm, i), last[i], (pexp - 1) * plen + 1 + int'(len) + i);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; read_len = '0; read_wgt_size = '0; num_pass = '0;
    repeat (2) @(negedge clk);
    chk("rst.rd_en", 32'(rd_en), 0);
    chk("rst.rd_clr", 32'(rd_clr), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    rst_n = 1'b1;

    run("k4_l3",     5'd4,  4,  13'd3,    8'd1, 1, 1'b0);
    run("k16_l4608", 5'd16, 16, 13'd4608, 8'd2, 2, 1'b0);
    run("sz0",       5'd0,  16, 13'd5,    8'd0, 1, 1'b0);
    run("sz20",      5'd20, 16, 13'd2,    8'd1, 1, 1'b0);
    run("l0",        5'd4,  4,  13'd0,    8'd3, 3, 1'b0);
    run("k1_l1",     5'd1,  1,  13'd1,    8'd1, 1, 1'b0);
    run("k1_l3_p2",  5'd1,  1,  13'd3,    8'd2, 2, 1'b0);
    run("poke",      5'd8,  8,  13'd6,    8'd3, 3, 1'b1);
    run("k3_l1_p3",  5'd3,  3,  13'd1,    8'd3, 3, 1'b0);

    // async reset in the middle of READ
    @(negedge clk);
    read_len = 13'd3; read_wgt_size = 5'd4; num_pass = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst.rd_en", 32'(rd_en), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.rd_en", 32'(rd_en), 0);
    chk("mid_rst.rd_clr", 32'(rd_clr), 0);
    chk("mid_rst.busy", 32'(busy), 0);
    chk("mid_rst.done", 32'(done), 0);
    @(negedge clk);
    chk("mid_rst.done2", 32'(done), 0);
    rst_n = 1'b1;
    run("after_rst", 5'd4, 4, 13'd3, 8'd1, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
